// File: rtl/fp_mul_arbiter.sv
// Shares one sequential FP multiplier between two requesters.
// The arbiter picks a requester round-robin, captures its operands, pulses
// Mul_Start, then waits for Mul_Done under a watchdog. It holds the result
// until the consumer takes it.
module fp_mul_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 40
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             Req0,
  input  logic             Req1,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] B0,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] B1,
  output logic             Gnt0,
  output logic             Gnt1,
  output logic             Mul_Start,
  output logic [WIDTH-1:0] Mul_A,
  output logic [WIDTH-1:0] Mul_B,
  input  logic             Mul_Done,
  input  logic [WIDTH-1:0] Mul_Result,
  output logic             Rsp_Valid,
  output logic             Rsp_Id,
  output logic [WIDTH-1:0] Rsp_Data,
  input  logic             Rsp_Ready,
  output logic             Timeout_Err,
  input  logic             Err_Clr,
  output logic             Busy
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] mul_a_q, mul_a_d;
  logic [WIDTH-1:0] mul_b_q, mul_b_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [CW-1:0]    count_q, count_d;
  logic             err_q, err_d;

  // State and datapath registers. Last resets to 1 so that requester 0
  // wins the first tie.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      id_q       <= 1'b0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      rsp_data_q <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      id_q       <= id_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      rsp_data_q <= rsp_data_d;
      count_q    <= count_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic: arbitration, watchdog, and the sticky error flag.
  // A watchdog set in the same cycle as Err_Clr overrides the clear.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    id_d       = id_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    rsp_data_d = rsp_data_q;
    count_d    = count_q;
    err_d      = err_q;
    if (Err_Clr) err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (Req0 && (!Req1 || last_q)) begin
          id_d    = 1'b0;
          mul_a_d = A0;
          mul_b_d = B0;
          state_d = ISSUE;
        end else if (Req1) begin
          id_d    = 1'b1;
          mul_a_d = A1;
          mul_b_d = B1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        count_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (Mul_Done) begin
          rsp_data_d = Mul_Result;
          state_d    = RESP;
        end else if (count_q == TO_CNT) begin
          rsp_data_d = '0;
          err_d      = 1'b1;
          state_d    = RESP;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      RESP: begin
        if (Rsp_Ready) begin
          last_d  = id_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control outputs are decoded from registered state only, so they are
  // glitch-free.
  always_comb begin
    Gnt0        = (state_q == ISSUE) && !id_q;
    Gnt1        = (state_q == ISSUE) && id_q;
    Mul_Start   = (state_q == ISSUE);
    Rsp_Valid   = (state_q == RESP);
    Busy        = (state_q != IDLE);
    Rsp_Id      = id_q;
    Rsp_Data    = rsp_data_q;
    Mul_A       = mul_a_q;
    Mul_B       = mul_b_q;
    Timeout_Err = err_q;
  end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter. The multiplier side is driven by the
// tasks themselves. Inputs change, and outputs are sampled, 1 time unit
// after the rising edge.
module tb_fp_mul_arbiter;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        Req0 = 1'b0, Req1 = 1'b0;
  logic [31:0] A0 = '0, B0 = '0, A1 = '0, B1 = '0;
  logic        Gnt0, Gnt1, Mul_Start;
  logic [31:0] Mul_A, Mul_B;
  logic        Mul_Done = 1'b0;
  logic [31:0] Mul_Result = '0;
  logic        Rsp_Valid, Rsp_Id;
  logic [31:0] Rsp_Data;
  logic        Rsp_Ready = 1'b0;
  logic        Timeout_Err;
  logic        Err_Clr = 1'b0;
  logic        Busy;

  int n_chk = 0;
  int n_fail = 0;

  fp_mul_arbiter #(.WIDTH(32), .TIMEOUT(40)) dut (
    .CLK(CLK), .RST_N(RST_N), .Req0(Req0), .Req1(Req1),
    .A0(A0), .B0(B0), .A1(A1), .B1(B1),
    .Gnt0(Gnt0), .Gnt1(Gnt1), .Mul_Start(Mul_Start),
    .Mul_A(Mul_A), .Mul_B(Mul_B), .Mul_Done(Mul_Done), .Mul_Result(Mul_Result),
    .Rsp_Valid(Rsp_Valid), .Rsp_Id(Rsp_Id), .Rsp_Data(Rsp_Data),
    .Rsp_Ready(Rsp_Ready), .Timeout_Err(Timeout_Err), .Err_Clr(Err_Clr),
    .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    step();
    step();
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    #1;
    n_chk++; if ({Gnt0, Gnt1, Mul_Start, Rsp_Valid, Rsp_Id, Timeout_Err, Busy} !== 7'b0) begin n_fail++; $display("FAIL reset_ctrl got %b exp 0", {Gnt0, Gnt1, Mul_Start, Rsp_Valid, Rsp_Id, Timeout_Err, Busy}); end
    n_chk++; if ({Mul_A, Mul_B, Rsp_Data} !== 96'b0) begin n_fail++; $display("FAIL reset_data got %h exp 0", {Mul_A, Mul_B, Rsp_Data}); end
    do_reset();
  endtask

  task automatic test_single();
    A0 = 32'h40000000; B0 = 32'h40400000; Req0 = 1'b1;
    step();
    n_chk++; if ({Gnt0, Gnt1, Mul_Start, Busy} !== 4'b1011) begin n_fail++; $display("FAIL single_issue got %b exp 1011", {Gnt0, Gnt1, Mul_Start, Busy}); end
    n_chk++; if (Mul_A !== 32'h40000000 || Mul_B !== 32'h40400000) begin n_fail++; $display("FAIL single_ops got %h/%h exp 40000000/40400000", Mul_A, Mul_B); end
    Req0 = 1'b0;
    step();
    n_chk++; if ({Gnt0, Mul_Start, Rsp_Valid, Busy} !== 4'b0001) begin n_fail++; $display("FAIL single_wait got %b exp 0001", {Gnt0, Mul_Start, Rsp_Valid, Busy}); end
    for (int i = 0; i < 24; i++) begin
      n_chk++; if (Rsp_Valid !== 1'b0) begin n_fail++; $display("FAIL single_early_rsp cyc %0d got %b exp 0", i, Rsp_Valid); end
      step();
    end
    Mul_Done = 1'b1; Mul_Result = 32'h40C00000;
    step();
    Mul_Done = 1'b0; Mul_Result = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      n_chk++; if ({Rsp_Valid, Rsp_Id, Rsp_Data} !== {1'b1, 1'b0, 32'h40C00000}) begin n_fail++; $display("FAIL single_rsp cyc %0d got %b/%b/%h exp 1/0/40c00000", i, Rsp_Valid, Rsp_Id, Rsp_Data); end
      if (i == 3) Rsp_Ready = 1'b1;
      step();
    end
    Rsp_Ready = 1'b0;
    n_chk++; if ({Rsp_Valid, Busy, Gnt0} !== 3'b000) begin n_fail++; $display("FAIL single_idle got %b exp 000", {Rsp_Valid, Busy, Gnt0}); end
  endtask

  task automatic test_round_robin();
    logic        exp_id;
    logic [31:0] exp_a;
    do_reset();
    A0 = 32'h11111111; B0 = 32'h22222222; A1 = 32'h33333333; B1 = 32'h44444444;
    Req0 = 1'b1; Req1 = 1'b1;
    for (int j = 0; j < 4; j++) begin
      exp_id = (j % 2 == 1);
      exp_a  = exp_id ? 32'h33333333 : 32'h11111111;
      step();
      n_chk++; if ({Gnt0, Gnt1} !== {!exp_id, exp_id}) begin n_fail++; $display("FAIL rr_gnt job %0d got %b%b exp id %0d", j, Gnt0, Gnt1, exp_id); end
      n_chk++; if (Mul_A !== exp_a) begin n_fail++; $display("FAIL rr_mul_a job %0d got %h exp %h", j, Mul_A, exp_a); end
      step();
      Mul_Done = 1'b1; Mul_Result = 32'h100 + j;
      step();
      Mul_Done = 1'b0;
      n_chk++; if ({Rsp_Valid, Rsp_Id, Rsp_Data} !== {1'b1, exp_id, 32'h100 + j}) begin n_fail++; $display("FAIL rr_rsp job %0d got %b/%b/%h exp 1/%0d/%h", j, Rsp_Valid, Rsp_Id, Rsp_Data, exp_id, 32'h100 + j); end
      Rsp_Ready = 1'b1;
      step();
      Rsp_Ready = 1'b0;
      n_chk++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL rr_idle_gap job %0d got %b exp 0", j, Busy); end
    end
    Req0 = 1'b0; Req1 = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    A1 = 32'h3F800000; B1 = 32'h3F800000; Req1 = 1'b1;
    step();
    n_chk++; if ({Gnt0, Gnt1} !== 2'b01) begin n_fail++; $display("FAIL to_gnt got %b%b exp 01", Gnt0, Gnt1); end
    Req1 = 1'b0;
    step();
    for (int i = 0; i <= 40; i++) begin
      n_chk++; if ({Rsp_Valid, Timeout_Err} !== 2'b00) begin n_fail++; $display("FAIL to_early cyc %0d got %b exp 00", i, {Rsp_Valid, Timeout_Err}); end
      if (i == 40) Err_Clr = 1'b1;
      step();
    end
    Err_Clr = 1'b0;
    n_chk++; if ({Rsp_Valid, Rsp_Id, Rsp_Data, Timeout_Err} !== {1'b1, 1'b1, 32'h0, 1'b1}) begin n_fail++; $display("FAIL to_rsp got %b/%b/%h err %b exp 1/1/0 err 1", Rsp_Valid, Rsp_Id, Rsp_Data, Timeout_Err); end
    Rsp_Ready = 1'b1;
    step();
    Rsp_Ready = 1'b0;
    Req0 = 1'b1; A0 = 32'h40000000; B0 = 32'h40000000;
    step();
    Req0 = 1'b0;
    step();
    Mul_Done = 1'b1; Mul_Result = 32'h40800000;
    step();
    Mul_Done = 1'b0;
    n_chk++; if ({Rsp_Data, Timeout_Err} !== {32'h40800000, 1'b1}) begin n_fail++; $display("FAIL to_sticky got %h err %b exp 40800000 err 1", Rsp_Data, Timeout_Err); end
    Rsp_Ready = 1'b1;
    step();
    Rsp_Ready = 1'b0; Err_Clr = 1'b1;
    step();
    Err_Clr = 1'b0;
    n_chk++; if (Timeout_Err !== 1'b0) begin n_fail++; $display("FAIL to_clear got %b exp 0", Timeout_Err); end
  endtask

  task automatic test_done_boundary();
    Req0 = 1'b1; A0 = 32'h40A00000; B0 = 32'h3F800000;
    step();
    Req0 = 1'b0; Mul_Done = 1'b1; Mul_Result = 32'h12345678;
    step();
    Mul_Done = 1'b0;
    n_chk++; if ({Rsp_Valid, Busy} !== 2'b01) begin n_fail++; $display("FAIL issue_done_ignored got %b exp 01", {Rsp_Valid, Busy}); end
    for (int i = 0; i < 40; i++) begin
      n_chk++; if (Rsp_Valid !== 1'b0) begin n_fail++; $display("FAIL edge_early cyc %0d got %b exp 0", i, Rsp_Valid); end
      step();
    end
    Mul_Done = 1'b1; Mul_Result = 32'h40A00000;
    step();
    Mul_Done = 1'b0;
    n_chk++; if ({Rsp_Valid, Rsp_Data, Timeout_Err} !== {1'b1, 32'h40A00000, 1'b0}) begin n_fail++; $display("FAIL edge_done got %b/%h err %b exp 1/40a00000 err 0", Rsp_Valid, Rsp_Data, Timeout_Err); end
    Rsp_Ready = 1'b1;
    step();
    Rsp_Ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    Req0 = 1'b1; A0 = 32'h40400000; B0 = 32'h40400000;
    step();
    Req0 = 1'b0;
    step();
    step();
    step();
    RST_N = 1'b0;
    #1;
    n_chk++; if ({Busy, Mul_Start, Rsp_Valid, Gnt0, Gnt1, Mul_A} !== 37'b0) begin n_fail++; $display("FAIL midrst_out got %b/%h exp 0", {Busy, Mul_Start, Rsp_Valid, Gnt0, Gnt1}, Mul_A); end
    step();
    RST_N = 1'b1;
    Mul_Done = 1'b1; Mul_Result = 32'h41100000;
    step();
    Mul_Done = 1'b0;
    n_chk++; if ({Rsp_Valid, Busy} !== 2'b00) begin n_fail++; $display("FAIL midrst_late_done got %b exp 00", {Rsp_Valid, Busy}); end
    Req1 = 1'b1; A1 = 32'h40E00000; B1 = 32'h3F000000;
    step();
    Req1 = 1'b0;
    n_chk++; if ({Gnt0, Gnt1, Mul_A} !== {2'b01, 32'h40E00000}) begin n_fail++; $display("FAIL midrst_gnt1 got %b%b/%h exp 01/40e00000", Gnt0, Gnt1, Mul_A); end
    step();
    Mul_Done = 1'b1; Mul_Result = 32'h40600000;
    step();
    Mul_Done = 1'b0;
    n_chk++; if ({Rsp_Valid, Rsp_Id, Rsp_Data} !== {1'b1, 1'b1, 32'h40600000}) begin n_fail++; $display("FAIL midrst_rsp got %b/%b/%h exp 1/1/40600000", Rsp_Valid, Rsp_Id, Rsp_Data); end
    Rsp_Ready = 1'b1;
    step();
    Rsp_Ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_done_boundary();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
